// File: rtl/andself_arb_seq.sv
// andself_arb_seq: round-robin arbiter that time-shares one 8-bit reduction-AND
// unit, streaming each granted word slice by slice and returning its full AND.
module andself_arb_seq #(
    parameter int NREQ   = 4,
    parameter int NSLICE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*8*NSLICE-1:0]   req_data,
    output logic [7:0]                 and_a,
    input  logic                       and_y,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NREQ)-1:0]    resp_id,
    output logic                       resp_y
);
    localparam int DW  = 8 * NSLICE;
    localparam int IDW = $clog2(NREQ);
    localparam int IXW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IXW-1:0]  r_idx;
    logic            r_acc;
    logic [DW-1:0]   r_word;
    logic            r_resp_valid;
    logic [IDW-1:0]  r_resp_id;
    logic            r_resp_y;
    logic [IDW-1:0]  w_gnt;
    logic            w_any;

    // Walk from the farthest offset back to rr_ptr so the nearest valid wins.
    always_comb begin : p_gnt
        int j;
        j     = 0;
        w_gnt = '0;
        w_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_rr_ptr) + k;
            j = j >= NREQ ? j - NREQ : j;
            if (req_valid[j[IDW-1:0]]) begin
                w_gnt = IDW'(j);
                w_any = 1'b1;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE && w_any) ? NREQ'(1) << w_gnt : '0;
    assign and_a      = r_state == S_RUN ? r_word[7:0] : 8'h00;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_y     = r_resp_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_idx        <= '0;
            r_acc        <= 1'b1;
            r_word       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_y     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_word    <= req_data[w_gnt*DW +: DW];
                    r_resp_id <= w_gnt;
                    r_rr_ptr  <= w_gnt == IDW'(NREQ - 1) ? '0 : w_gnt + IDW'(1);
                    r_idx     <= '0;
                    r_acc     <= 1'b1;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    r_acc  <= r_acc & and_y;
                    r_word <= r_word >> 8;
                    if (!and_y || r_idx == IXW'(NSLICE - 1)) begin
                        r_resp_y     <= r_acc & and_y;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_idx <= r_idx + IXW'(1);
                    end
                end
                S_RESP: if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_andself_arb_seq.sv
// tb_andself_arb_seq: directed and random checks of the shared reduction-AND
// arbiter against a transaction-level model of grant order, latency and result.
module tb_andself_arb_seq;
    localparam int NREQ   = 4;
    localparam int NSLICE = 4;
    localparam int DW     = 8 * NSLICE;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_data;
    logic [7:0]           and_a;
    logic                 and_y;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_id;
    logic                 resp_y;

    int n_checks = 0;
    int n_pass   = 0;
    int n_resp   = 0;

    andself_arb_seq #(.NREQ(NREQ), .NSLICE(NSLICE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .and_a(and_a), .and_y(and_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_y(resp_y)
    );

    // The shared unit itself.
    assign and_y = &and_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Cycles spent streaming: up to and including the first non-FF slice.
    function automatic int run_len(input logic [DW-1:0] w);
        for (int k = 0; k < NSLICE; k++)
            if (w[8*k +: 8] != 8'hFF) return k + 1;
        return NSLICE;
    endfunction

    // Model: phase 0 idle, 1 streaming, 2 holding a response.
    int              m_phase   = 0;
    int              m_ptr     = 0;
    int              m_pos     = 0;
    int              m_len     = 0;
    int              m_id      = 0;
    logic            m_y       = 1'b0;
    logic [DW-1:0]   m_word    = '0;
    bit              m_started = 1'b0;
    int              wcnt [NREQ];

    always @(negedge clk) begin : p_cmp
        int g;
        int gd;
        int wmax;
        g = rr_pick(req_valid, m_ptr);
        if (m_started) begin
            chk("m_req_ready", 64'(req_ready), (m_phase == 0 && g >= 0) ? 64'(1 << g) : 64'd0);
            chk("m_and_a", 64'(and_a), m_phase == 1 ? 64'(m_word[8*m_pos +: 8]) : 64'd0);
            chk("m_resp_valid", 64'(resp_valid), 64'(m_phase == 2));
            if (m_phase == 2) begin
                chk("m_resp_id", 64'(resp_id), 64'(m_id));
                chk("m_resp_y", 64'(resp_y), 64'(m_y));
            end
            if (req_ready != '0 && !rst) begin
                gd = 0;
                wmax = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gd = i;
                for (int i = 0; i < NREQ; i++) begin
                    wcnt[i] = (i != gd && req_valid[i]) ? wcnt[i] + 1 : 0;
                    if (wcnt[i] > wmax) wmax = wcnt[i];
                end
                chk("fair_wait_exceeded", 64'(wmax >= NREQ), 64'd0);
            end
        end
        if (rst) begin
            m_phase   = 0;
            m_ptr     = 0;
            m_started = 1'b1;
            for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
        end else if (m_started) begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_word  = req_data[g*DW +: DW];
                    m_id    = g;
                    m_y     = &m_word;
                    m_len   = run_len(m_word);
                    m_pos   = 0;
                    m_ptr   = (g + 1) % NREQ;
                    m_phase = 1;
                end
                1: begin
                    m_pos++;
                    if (m_pos == m_len) m_phase = 2;
                end
                default: if (resp_ready) begin
                    m_phase = 0;
                    n_resp++;
                end
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_resp(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (!resp_valid && c < 30) begin
            c++;
            @(negedge clk);
        end
        if (!resp_valid) chk({nm, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Single request from requester r; checks latency, slice stream and result.
    task automatic txn(input string nm, input int r, input logic [DW-1:0] w,
                       input int lat, input logic y, input logic [63:0] seq_exp);
        logic [63:0] seq;
        int c;
        @(posedge clk); #1;
        req_valid = 4'(1 << r);
        req_data  = '0;
        req_data[r*DW +: DW] = w;
        @(negedge clk);
        chk({nm, "_ready"}, 64'(req_ready), 64'(1 << r));
        @(posedge clk); #1;
        req_valid = '0;
        seq = '0;
        c = 1;
        @(negedge clk);
        while (!resp_valid && c < 20) begin
            seq = {seq[55:0], and_a};
            c++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 64'(c), 64'(lat));
        chk({nm, "_and_a_seq"}, seq, seq_exp);
        chk({nm, "_resp_id"}, 64'(resp_id), 64'(r));
        chk({nm, "_resp_y"}, 64'(resp_y), 64'(y));
    endtask

    logic [3:0] t3_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        int n;
        int c;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_y", 64'(resp_y), 64'd0);
        chk("rst_and_a", 64'(and_a), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);

        txn("t1", 0, 32'hFFFF_FFFF, 5, 1'b1, 64'hFFFF_FFFF);
        txn("t2", 2, 32'hFFFF_00FF, 3, 1'b0, 64'hFF00);
        txn("t2_last", 3, 32'h7FFF_FFFF, 5, 1'b0, 64'hFFFF_FF7F);
        txn("t2_first", 1, 32'hFFFF_FF00, 2, 1'b0, 64'h00);

        do_reset();
        req_data  = {4{32'hFFFF_FFFF}};
        req_valid = 4'b1111;
        n = 0;
        c = 0;
        while (n < 6 && c < 80) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("t3_grant", 64'(req_ready), 64'(t3_exp[n]));
                n++;
            end
            c++;
        end
        chk("t3_grant_count", 64'(n), 64'd6);

        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_resp("t4");
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_valid", 64'(resp_valid), 64'd1);
            chk("t4_hold_id", 64'(resp_id), 64'd1);
            chk("t4_hold_y", 64'(resp_y), 64'd1);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_valid", 64'(resp_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_idle_valid", 64'(resp_valid), 64'd0);
        chk("t4_idle_grant", 64'(req_ready), 64'b0100);

        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t5_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_and_a_run2", 64'(and_a), 64'hFF);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t5_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_and_a", 64'(and_a), 64'd0);
        chk("t5_grant", 64'(req_ready), 64'b0001);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            req_valid  = 4'($urandom);
            resp_ready = $urandom_range(0, 3) != 0;
            for (int b = 0; b < NREQ * NSLICE; b++)
                req_data[8*b +: 8] = $urandom_range(0, 3) != 0 ? 8'hFF : 8'($urandom);
        end
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_enough_responses", 64'(n_resp > 150), 64'd1);
        chk("t6_drained", 64'(resp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
